// File: rtl/dot_sched_pkg.sv
// Shared types for the dot-product scheduler: FSM state encoding and the
// result-width rule used by both the scheduler and the engine.
package dot_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

    // Full-precision dot-product width: product width plus growth for N terms.
    function automatic int dot_rw(input int width, input int n);
        return 2 * width + $clog2(n);
    endfunction

endpackage

// File: rtl/dot_product_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first request at or after
// the pointer (wrapping) and reports the pointer to use after this grant.
module rr_arbiter #(
    parameter  int NREQ = 2,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx,
    output logic [PW-1:0]   nxt_ptr,
    output logic            any
);

    logic [PW-1:0] ci;

    // Scan from the pointer; the first live request found wins.
    always_comb begin
        grant   = '0;
        idx     = '0;
        nxt_ptr = '0;
        any     = 1'b0;
        ci      = '0;
        for (int i = 0; i < NREQ; i++) begin
            ci = PW'((int'(ptr) + i) % NREQ);
            if (!any && req[ci]) begin
                any       = 1'b1;
                grant[ci] = 1'b1;
                idx       = ci;
                nxt_ptr   = PW'((int'(ci) + 1) % NREQ);
            end
        end
    end

endmodule

// File: rtl/dot_product_sched.sv
// Round-robin scheduler sharing one streaming dot-product engine among NREQ
// requesters. A granted requester's N element pairs are streamed one per
// cycle, the engine drains on its own, and the result returns with a
// one-cycle done pulse.
// Optional feature: DOT_SCHED_TIMEOUT_EN bounds the drain wait to TIMEOUT
// cycles and reports an expired job with err=1 and result=0.
module dot_product_sched
    import dot_sched_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int N       = 4,
    parameter  int NREQ    = 2,
    parameter  int TIMEOUT = 16,
    localparam int RW      = dot_rw(WIDTH, N)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*N*WIDTH-1:0] a_flat,
    input  logic [NREQ*N*WIDTH-1:0] b_flat,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         done,
    output logic [RW-1:0]           result,
    output logic                    err,
    output logic                    busy,
    output logic                    eng_valid,
    output logic [WIDTH-1:0]        eng_a,
    output logic [WIDTH-1:0]        eng_b,
    input  logic [RW-1:0]           eng_result,
    input  logic                    eng_out_valid
);

    localparam int KW = $clog2(N);
    localparam int PW = $clog2(NREQ);

    // Parameter sanity, caught at elaboration.
    if (N < 2)       begin : g_chk_n       $error("N must be >= 2");       end
    if (NREQ < 2)    begin : g_chk_nreq    $error("NREQ must be >= 2");    end
    if (TIMEOUT < 1) begin : g_chk_timeout $error("TIMEOUT must be >= 1"); end

    sched_state_t    state, state_nxt;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   gidx;
    logic [KW-1:0]   k;
    logic            k_last;

    logic [NREQ-1:0] arb_grant;
    logic [PW-1:0]   arb_idx;
    logic [PW-1:0]   arb_nxt;
    logic            arb_any;

`ifdef DOT_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]   dcnt;
    logic            err_q;
    logic            dto;
    assign dto = (dcnt == TW'(TIMEOUT - 1));
`endif

    // Element view of the flat vector buses: a_el[r][i] is requester r, element i.
    logic [WIDTH-1:0] a_el [NREQ][N];
    logic [WIDTH-1:0] b_el [NREQ][N];

    for (genvar r = 0; r < NREQ; r++) begin : g_req
        for (genvar i = 0; i < N; i++) begin : g_elem
            assign a_el[r][i] = a_flat[(r*N+i)*WIDTH +: WIDTH];
            assign b_el[r][i] = b_flat[(r*N+i)*WIDTH +: WIDTH];
        end
    end

    assign k_last = (k == KW'(N - 1));

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (req),
        .ptr     (ptr),
        .grant   (arb_grant),
        .idx     (arb_idx),
        .nxt_ptr (arb_nxt),
        .any     (arb_any)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: IDLE -> FEED -> DRAIN -> RESP -> IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (arb_any) state_nxt = FEED;
            FEED:  if (k_last)  state_nxt = DRAIN;
            DRAIN: begin
                if (eng_out_valid) state_nxt = RESP;
`ifdef DOT_SCHED_TIMEOUT_EN
                else if (dto)      state_nxt = RESP;
`endif
            end
            RESP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant, pointer, element counter and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt    <= '0;
            gidx   <= '0;
            ptr    <= '0;
            k      <= '0;
            result <= '0;
`ifdef DOT_SCHED_TIMEOUT_EN
            dcnt   <= '0;
            err_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    k <= '0;
                    if (arb_any) begin
                        gnt  <= arb_grant;
                        gidx <= arb_idx;
                        ptr  <= arb_nxt;
`ifdef DOT_SCHED_TIMEOUT_EN
                        err_q <= 1'b0;
`endif
                    end
                end
                FEED: begin
                    k <= k_last ? '0 : k + KW'(1);
`ifdef DOT_SCHED_TIMEOUT_EN
                    dcnt <= '0;
`endif
                end
                DRAIN: begin
                    if (eng_out_valid) begin
                        result <= eng_result;
                    end
`ifdef DOT_SCHED_TIMEOUT_EN
                    else if (dto) begin
                        result <= '0;
                        err_q  <= 1'b1;
                    end else begin
                        dcnt <= dcnt + TW'(1);
                    end
`endif
                end
                RESP: gnt <= '0;
                default: ;
            endcase
        end
    end

    // Outputs: element mux during FEED, done pulse during RESP.
    always_comb begin
        eng_valid = (state == FEED);
        eng_a     = '0;
        eng_b     = '0;
        if (state == FEED) begin
            eng_a = a_el[gidx][k];
            eng_b = b_el[gidx][k];
        end
        done = (state == RESP) ? gnt : '0;
        busy = (state != IDLE);
`ifdef DOT_SCHED_TIMEOUT_EN
        err  = (state == RESP) && err_q;
`else
        err  = 1'b0;
`endif
    end

endmodule

// File: tb/tb_dot_product_sched.sv
// Scoreboard bench for dot_product_sched with a behavioural engine model.
// Expected (requester, result, err) entries are queued from a round-robin
// reference model; a negedge monitor pops one per done pulse.
module tb_dot_product_sched;
    import dot_sched_pkg::*;

    localparam int WIDTH   = 8;
    localparam int N       = 4;
    localparam int NREQ    = 2;
    localparam int TIMEOUT = 16;
    localparam int RW      = dot_rw(WIDTH, N);

    typedef struct {
        int     idx;
        longint res;
        bit     err;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NREQ-1:0]         req = '0;
    logic [NREQ*N*WIDTH-1:0] a_flat, b_flat;
    logic [NREQ-1:0]         gnt, done;
    logic [RW-1:0]           result;
    logic                    err, busy, eng_valid;
    logic [WIDTH-1:0]        eng_a, eng_b;
    logic [RW-1:0]           eng_result;
    logic                    eng_out_valid;

    logic [WIDTH-1:0] A [NREQ][N];
    logic [WIDTH-1:0] B [NREQ][N];

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   mptr   = 0;
    int   dlat   = 2;
    bit   eng_en = 1'b1;

    always #5 clk = ~clk;

    dot_product_sched #(.WIDTH(WIDTH), .N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .a_flat        (a_flat),
        .b_flat        (b_flat),
        .gnt           (gnt),
        .done          (done),
        .result        (result),
        .err           (err),
        .busy          (busy),
        .eng_valid     (eng_valid),
        .eng_a         (eng_a),
        .eng_b         (eng_b),
        .eng_result    (eng_result),
        .eng_out_valid (eng_out_valid)
    );

    // Pack bench vector arrays onto the flat buses.
    always_comb begin
        a_flat = '0;
        b_flat = '0;
        for (int r = 0; r < NREQ; r++)
            for (int i = 0; i < N; i++) begin
                a_flat[(r*N+i)*WIDTH +: WIDTH] = A[r][i];
                b_flat[(r*N+i)*WIDTH +: WIDTH] = B[r][i];
            end
    end

    // Behavioural streaming engine: accumulate N products, present the sum dlat cycles later.
    logic [RW-1:0] acc;
    int            ecnt, ecd;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0; ecnt <= 0; ecd <= 0; eng_result <= '0; eng_out_valid <= 1'b0;
        end else begin
            eng_out_valid <= 1'b0;
            if (eng_valid) begin
                if (ecnt == N - 1) begin
                    eng_result <= acc + RW'(eng_a) * RW'(eng_b);
                    acc        <= '0;
                    ecnt       <= 0;
                    ecd        <= dlat;
                end else begin
                    acc  <= acc + RW'(eng_a) * RW'(eng_b);
                    ecnt <= ecnt + 1;
                end
            end
            if (ecd > 0) begin
                ecd <= ecd - 1;
                if (ecd == 1) eng_out_valid <= eng_en;
            end
        end
    end

    // Monitor: structural checks every cycle, scoreboard pop on each done.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ($countones(gnt) > 1) begin
                errors++; $display("FAIL gnt_onehot got %b", gnt);
            end
            checks++;
            if (!eng_valid && (eng_a != '0 || eng_b != '0)) begin
                errors++; $display("FAIL eng_idle_zero got a=%0d b=%0d", eng_a, eng_b);
            end
            if (done != '0) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL done_unexpected got done=%b", done);
                end else begin
                    mon_e = q.pop_front();
                    if (done != (NREQ'(1) << mon_e.idx) || gnt != done ||
                        longint'(result) != mon_e.res || err != mon_e.err) begin
                        errors++;
                        $display("FAIL job got done=%b gnt=%b result=%0d err=%0d exp done=%b result=%0d err=%0d",
                                 done, gnt, result, err, NREQ'(1) << mon_e.idx, mon_e.res, mon_e.err);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", nm, got, exp);
        end
    endtask

    function automatic longint ref_dot(input int r);
        longint s = 0;
        for (int i = 0; i < N; i++) s += longint'(A[r][i]) * longint'(B[r][i]);
        return s;
    endfunction

    // Round-robin reference: first requester at/after mptr, pointer then moves past it.
    task automatic pick(input logic [NREQ-1:0] p, output int r);
        r = -1;
        for (int i = 0; i < NREQ; i++) begin
            int c;
            c = (mptr + i) % NREQ;
            if (r < 0 && ((p >> c) & NREQ'(1)) != '0) r = c;
        end
        if (r >= 0) mptr = (r + 1) % NREQ;
    endtask

    task automatic push_job(input int r, input bit e_err);
        exp_t e;
        e.idx = r;
        e.res = e_err ? 0 : ref_dot(r);
        e.err = e_err;
        q.push_back(e);
    endtask

    task automatic rand_data();
        for (int r = 0; r < NREQ; r++)
            for (int i = 0; i < N; i++) begin
                A[r][i] = ($urandom_range(0, 7) == 0) ? '1 : WIDTH'($urandom);
                B[r][i] = ($urandom_range(0, 7) == 0) ? '1 : WIDTH'($urandom);
            end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        q.delete();
        mptr = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Wait (bounded) for a done pulse; optionally withdraw that requester.
    task automatic wait_done(input bit clr);
        bit got = 1'b0;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            if (done != '0) begin
                got = 1'b1;
                if (clr) req = req & ~done;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL wait_done got no done within 200 cycles exp a done pulse");
        end
    endtask

    task automatic wait_eng_valid();
        bit got = 1'b0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            if (eng_valid) got = 1'b1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL wait_eng_valid got no eng_valid within 50 cycles exp eng_valid=1");
        end
    endtask

    // Serve pattern p for njobs jobs; hold keeps req asserted across jobs.
    task automatic serve(input logic [NREQ-1:0] p, input int njobs, input bit hold);
        logic [NREQ-1:0] cur = p;
        int r;
        req = p;
        for (int j = 0; j < njobs; j++) begin
            pick(cur, r);
            push_job(r, 1'b0);
            if (!hold) cur = cur & ~(NREQ'(1) << r);
        end
        for (int j = 0; j < njobs; j++) wait_done(!hold);
        req = '0;
        repeat (2) @(negedge clk);
        chk("idle_after_jobs", longint'(busy), 0);
        chk("queue_drained", longint'(q.size()), 0);
    endtask

    initial begin
        int r;
        for (int rr = 0; rr < NREQ; rr++)
            for (int i = 0; i < N; i++) begin A[rr][i] = '0; B[rr][i] = '0; end

        // Reset values
        rst = 1'b1;
        @(negedge clk);
        chk("rst_gnt", longint'(gnt), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_err", longint'(err), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_eng_valid", longint'(eng_valid), 0);
        chk("rst_eng_ab", longint'(eng_a) + longint'(eng_b), 0);
        chk("rst_result", longint'(result), 0);
        do_reset();

        // Single job with known vectors: 1*10 + 2*1 + 3*0 + 4*2 = 20
        A[0] = '{8'd1, 8'd2, 8'd3, 8'd4};
        B[0] = '{8'd10, 8'd1, 8'd0, 8'd2};
        chk("ref_single", ref_dot(0), 20);
        serve(2'b01, 1, 1'b0);

        // Contention from ptr=0: R0 (4) first, then R1 (1020)
        do_reset();
        A[0] = '{8'd1, 8'd1, 8'd1, 8'd1};
        B[0] = '{8'd1, 8'd1, 8'd1, 8'd1};
        A[1] = '{8'd255, 8'd255, 8'd255, 8'd255};
        B[1] = '{8'd1, 8'd1, 8'd1, 8'd1};
        chk("ref_contention", ref_dot(1), 1020);
        serve(2'b11, 2, 1'b0);

        // Fairness: both held for 6 jobs, grants must alternate
        do_reset();
        rand_data();
        serve(2'b11, 6, 1'b1);

        // Maximum-magnitude result, no truncation: 4*255*255
        do_reset();
        for (int i = 0; i < N; i++) begin A[1][i] = '1; B[1][i] = '1; end
        chk("ref_max", ref_dot(1), 260100);
        serve(2'b10, 1, 1'b0);

        // Withdrawal: R0 drops req mid-FEED, its job still completes; R1 follows
        do_reset();
        rand_data();
        req = 2'b11;
        pick(2'b11, r); push_job(r, 1'b0);
        pick(2'b10, r); push_job(r, 1'b0);
        wait_eng_valid();
        @(negedge clk);
        req[0] = 1'b0;
        wait_done(1'b1);
        wait_done(1'b1);
        repeat (2) @(negedge clk);
        chk("withdraw_idle", longint'(busy), 0);
        chk("withdraw_queue", longint'(q.size()), 0);

        // Randomized rounds with varying engine drain latency
        for (int n = 0; n < 20; n++) begin
            logic [NREQ-1:0] p;
            dlat = $urandom_range(1, 5);
            rand_data();
            p = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            serve(p, $countones(p), 1'b0);
        end
        dlat = 2;

        // Reset mid-FEED at k=2, then a fresh job
        do_reset();
        rand_data();
        req = 2'b01;
        pick(2'b01, r); push_job(r, 1'b0);
        wait_eng_valid();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        q.delete();
        mptr = 0;
        req = '0;
        #1;
        chk("midrst_eng_valid", longint'(eng_valid), 0);
        chk("midrst_gnt", longint'(gnt), 0);
        chk("midrst_busy", longint'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rand_data();
        serve(2'b01, 1, 1'b0);

        // Engine never answers
        do_reset();
        rand_data();
        eng_en = 1'b0;
`ifdef DOT_SCHED_TIMEOUT_EN
        req = 2'b01;
        pick(2'b01, r); push_job(r, 1'b1);
        wait_done(1'b1);
        repeat (2) @(negedge clk);
        chk("timeout_idle", longint'(busy), 0);
        chk("timeout_queue", longint'(q.size()), 0);
`else
        req = 2'b01;
        repeat (60) @(negedge clk);
        chk("hang_busy", longint'(busy), 1);
        chk("hang_err", longint'(err), 0);
`endif
        do_reset();
        eng_en = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
